// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter4
//  Purpose  : Four-requester round-robin arbiter with a hold limit. A
//             requester that wins keeps the grant for as long as it keeps
//             requesting, unless another requester is waiting. In that case
//             the owner loses the grant after MAX_HOLD cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  clock; every register updates on its rising edge
//    reset_n   in   1  asynchronous, active-low reset
//    req       in   4  level request per requester (bit i = requester i)
//    gnt       out  4  registered one-hot grant, zero when there is no owner
//    sel       out  2  registered index of the current or last owner
//                      (select input of the shared 4:1 mux)
//    valid     out  1  registered; high exactly when gnt is nonzero
//    hold_cnt  out  8  registered count of cycles the owner has held gnt
//  Parameters
//    MAX_HOLD  maximum consecutive grant cycles while another requester is
//              pending (legal range 2..255)
// ============================================================================
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic [7:0] hold_cnt
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_valid;
    logic [7:0] r_hold;

    // Next-state values
    state_t     w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_valid_nxt;
    logic [7:0] w_hold_nxt;

    // Arbitration signals
    logic [3:0] w_cand;
    logic [2:0] w_pick;
    logic       w_found;
    logic [1:0] w_win;
    logic [3:0] w_win_onehot;
    logic       w_owner_req;
    logic       w_hold_below_max;

    // ------------------------------------------------------------------
    // Round-robin search. Starting at 'start', the function returns
    // {found, index} for the first set bit of 'mask'. It walks the
    // offsets from farthest to nearest, so the nearest hit is the last
    // value written and no early exit is needed.
    // ------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    // The current owner is masked out of the candidate set. The pointer
    // already sits one past the owner, so the owner could only be found
    // last anyway. Masking it also means that a forced rotation or a
    // hand-over always picks a *different* requester. In IDLE r_gnt is
    // zero, so the mask has no effect there.
    assign w_cand       = req & ~r_gnt;
    assign w_pick       = rr_pick(w_cand, r_ptr);
    assign w_found      = w_pick[2];
    assign w_win        = w_pick[1:0];
    assign w_win_onehot = 4'b0001 << w_win;

    assign w_owner_req      = |(req & r_gnt);
    assign w_hold_below_max = (r_hold < c_max_hold);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;

        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_win_onehot;
                    w_sel_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd1;
                    w_ptr_nxt   = w_win + 2'd1;
                end else begin
                    // sel deliberately keeps the last owner index
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = 8'd0;
                end
            end

            ST_GRANT: begin
                if (w_owner_req && w_hold_below_max) begin
                    w_hold_nxt = r_hold + 8'd1;
                end else if (w_found) begin
                    // Either the owner has used up its hold budget or it has
                    // dropped its request. In both cases the grant moves
                    // straight to the next winner with no idle bubble.
                    w_gnt_nxt   = w_win_onehot;
                    w_sel_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd1;
                    w_ptr_nxt   = w_win + 2'd1;
                end else if (w_owner_req) begin
                    // Nobody else is waiting: keep the owner and saturate.
                    w_hold_nxt = c_max_hold;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = 8'd0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Every output comes straight from a register. There is no
    // combinational path from req to the outputs.
    assign gnt      = r_gnt;
    assign sel      = r_sel;
    assign valid    = r_valid;
    assign hold_cnt = r_hold;

`ifndef SYNTHESIS
    // Grant integrity: at most one bit set, and sel/valid consistent.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ($onehot0(r_gnt));
            assert (r_valid == (r_gnt != 4'b0000));
            assert (!r_valid || (r_gnt == (4'b0001 << r_sel)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter4
//  Purpose  : Self-checking bench for rr_arbiter4 (MAX_HOLD = 8). A table of
//             {req, expected outputs} records is applied one clock at a time.
//             Hand-written sequences then cover reset behaviour, the exact
//             two-requester rotation from ptr=0, an asynchronous reset pulse
//             during a grant, and all four requesters held high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter4;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] hold_cnt;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] hold;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .valid    (valid),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg,
                              input logic [1:0] es, input logic ev,
                              input logic [7:0] eh);
        check({tag, ".gnt"},      {4'b0, gnt},          {4'b0, eg});
        check({tag, ".sel"},      {6'b0, sel},          {6'b0, es});
        check({tag, ".valid"},    {7'b0, valid},        {7'b0, ev});
        check({tag, ".hold_cnt"}, hold_cnt,             eh);
        check({tag, ".onehot"},   {7'b0, $onehot0(gnt)}, 8'd1);
    endtask

    // Drive req, let one rising edge pass, and sample 1 ns after it.
    task automatic step(input string tag, input logic [3:0] r,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic ev, input logic [7:0] eh);
        req = r;
        @(posedge clk);
        #1;
        check_outs(tag, eg, es, ev, eh);
    endtask

    task automatic add_vec(input logic [3:0] r, input logic [3:0] g,
                           input logic [1:0] s, input logic v, input int h);
        vec_t t;
        t.req   = r;
        t.gnt   = g;
        t.sel   = s;
        t.valid = v;
        t.hold  = 8'(h);
        vecs.push_back(t);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_outs(tag, 4'b0000, 2'd0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        req     = 4'b0000;
        reset_n = 1'b1;

        // ---------------- vector table ----------------
        // Single requester 2: latency one edge, count to 8, then saturate.
        for (int k = 1; k <= 10; k++)
            add_vec(4'b0100, 4'b0100, 2'd2, 1'b1, (k > 8) ? 8 : k);
        // Owner drops with nobody else waiting: go idle, sel keeps 2.
        add_vec(4'b0000, 4'b0000, 2'd2, 1'b0, 0);
        // ptr=3: search 3,0 -> 0.
        add_vec(4'b0001, 4'b0001, 2'd0, 1'b1, 1);
        // Requester 1 joins: owner 0 keeps the grant up to hold 8, then rotates.
        for (int k = 2; k <= 8; k++)
            add_vec(4'b0011, 4'b0001, 2'd0, 1'b1, k);
        for (int k = 1; k <= 8; k++)
            add_vec(4'b0011, 4'b0010, 2'd1, 1'b1, k);
        add_vec(4'b0011, 4'b0001, 2'd0, 1'b1, 1);
        // Owner 0 drops, requester 1 is waiting: direct hand-over.
        add_vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1);
        add_vec(4'b1010, 4'b0010, 2'd1, 1'b1, 2);
        // Owner 1 drops while req[3] is high: no valid=0 bubble.
        add_vec(4'b1000, 4'b1000, 2'd3, 1'b1, 1);
        add_vec(4'b1000, 4'b1000, 2'd3, 1'b1, 2);
        add_vec(4'b0000, 4'b0000, 2'd3, 1'b0, 0);
        add_vec(4'b0000, 4'b0000, 2'd3, 1'b0, 0);
        // From IDLE with ptr=0: search 0,1 -> 1.
        add_vec(4'b0110, 4'b0010, 2'd1, 1'b1, 1);
        // Owner 1 drops and 0 and 2 are set. ptr=2 gives 2.
        add_vec(4'b0101, 4'b0100, 2'd2, 1'b1, 1);
        // Owner 2 alone saturates, then requester 0 forces a rotation (ptr=3).
        for (int k = 2; k <= 10; k++)
            add_vec(4'b0100, 4'b0100, 2'd2, 1'b1, (k > 8) ? 8 : k);
        add_vec(4'b0101, 4'b0001, 2'd0, 1'b1, 1);

        // ---------------- reset state (asynchronous, before any edge) ----
        #1;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset_t0", 4'b0000, 2'd0, 1'b0, 8'd0);
        do_reset("reset");

        // First edge after reset with req=0 stays idle.
        step("post_reset_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 8'd0);

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt,
                 vecs[i].sel, vecs[i].valid, vecs[i].hold);

        // ---------------- req=0011 from reset (ptr=0) --------------------
        do_reset("reset2");
        for (int c = 1; c <= 17; c++) begin
            logic [1:0] own;
            own = 2'(((c - 1) / 8) % 2);
            step($sformatf("rot2_c%0d", c), 4'b0011, 4'b0001 << own, own,
                 1'b1, 8'(((c - 1) % 8) + 1));
        end

        // ---------------- reset pulse during a grant -----------------------
        do_reset("reset3");
        step("pre_pulse", 4'b0100, 4'b0100, 2'd2, 1'b1, 8'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_outs("mid_pulse", 4'b0000, 2'd0, 1'b0, 8'd0);
        #1;
        reset_n = 1'b1;
        // ptr restarts at 0, so 1111 picks requester 0.
        step("all_c1", 4'b1111, 4'b0001, 2'd0, 1'b1, 8'd1);

        // ---------------- req=1111 held: 0,1,2,3,0 with 8 cycles each -------
        for (int c = 2; c <= 33; c++) begin
            logic [1:0] own;
            own = 2'(((c - 1) / 8) % 4);
            step($sformatf("all_c%0d", c), 4'b1111, 4'b0001 << own, own,
                 1'b1, 8'(((c - 1) % 8) + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
